// File: rtl/cacheline_arbiter_pkg.sv
// cacheline_arb_pkg: shared state/source types and default bus widths for the cacheline arbiter
package cacheline_arb_pkg;
  localparam int LINE_W_DEF = 256;
  localparam int ADDR_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} arb_state_t;
  typedef enum logic {SRC_I, SRC_D} arb_src_t;
endpackage

// File: rtl/cacheline_arbiter_if.sv
// cacheline_arbiter_if: I-cache, D-cache and physical-memory cacheline buses around the arbiter
interface cacheline_arbiter_if #(
  parameter int LINE_W = cacheline_arb_pkg::LINE_W_DEF,
  parameter int ADDR_W = cacheline_arb_pkg::ADDR_W_DEF
);
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              arb_busy;
  modport master (
    input  i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  pmem_rdata, pmem_resp,
    output i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata, arb_busy
  );
  modport slave (
    output i_pmem_read, i_pmem_address, d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output pmem_rdata, pmem_resp,
    input  i_pmem_rdata, i_pmem_resp, d_pmem_rdata, d_pmem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata, arb_busy
  );
endinterface

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin sharing of one pmem cacheline port between the I-cache and D-cache
module cacheline_arbiter
  import cacheline_arb_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic clk,
  input logic rst,
  cacheline_arbiter_if.master bus
);
  arb_state_t state, state_n;
  arb_src_t last_grant;
  logic i_req, d_req, grant, pick_d, resp_ok;
  logic rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  always_comb begin
    i_req = bus.i_pmem_read;
    d_req = bus.d_pmem_read | bus.d_pmem_write;
    pick_d = d_req & (~i_req | (last_grant == SRC_I));
    grant = (state == IDLE) & (i_req | d_req);
    state_n = state == IDLE ? (grant ? (pick_d ? SERVE_D : SERVE_I) : IDLE)
            : state == DONE ? IDLE
            : bus.pmem_resp ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // Writeback beats fill when D asks for both, so a dirty victim leaves before its replacement arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= SRC_I;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      last_grant <= pick_d ? SRC_D : SRC_I;
      addr_q <= pick_d ? bus.d_pmem_address : bus.i_pmem_address;
      if (pick_d) wdata_q <= bus.d_pmem_wdata;
      rd_q <= ~pick_d | ~bus.d_pmem_write;
      wr_q <= pick_d & bus.d_pmem_write;
    end else if (state_n == DONE) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end
  end
  // A response landing in the reset cycle belongs to an aborted transaction and is dropped.
  assign resp_ok = bus.pmem_resp & ~rst;
  assign bus.i_pmem_resp = resp_ok & (state == SERVE_I);
  assign bus.d_pmem_resp = resp_ok & (state == SERVE_D);
  assign bus.i_pmem_rdata = bus.i_pmem_resp ? bus.pmem_rdata : '0;
  assign bus.d_pmem_rdata = bus.d_pmem_resp ? bus.pmem_rdata : '0;
  assign bus.pmem_read = rd_q;
  assign bus.pmem_write = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.arb_busy = state != IDLE;
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed vectors with transaction/response scoreboards and a latency-programmable memory model
module tb_cacheline_arbiter;
  typedef struct {logic rd; logic wr; logic [31:0] addr; logic [255:0] wdata;} txn_t;
  typedef struct {logic d; logic [255:0] data;} rsp_t;
  logic clk = 0;
  logic rst;
  logic mon_en;
  int mem_lat;
  int spur_req;
  int vectors = 0;
  int miscompares = 0;
  txn_t txn_q[$];
  rsp_t rsp_q[$];
  cacheline_arbiter_if #(.LINE_W(256), .ADDR_W(32)) bus ();
  cacheline_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [255:0] line_of(input logic [31:0] a);
    return a == 32'h60 ? {32{8'hAA}} : {8{a}};
  endfunction
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic exp_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [255:0] w);
    txn_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.wdata = w;
    txn_q.push_back(t);
  endtask
  task automatic exp_rsp(input logic d, input logic [255:0] data);
    rsp_t r;
    r.d = d; r.data = data;
    rsp_q.push_back(r);
  endtask
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.i_pmem_resp || bus.d_pmem_resp) && n < 100);
    check("resp_wait", 256'(n < 100), 256'(1));
  endtask
  initial begin
    int cnt;
    int ack;
    cnt = 0;
    ack = 0;
    bus.pmem_resp = 0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pmem_resp = 0;
      if (spur_req != ack) begin
        ack++;
        bus.pmem_resp = 1;
        bus.pmem_rdata = '1;
      end else if (bus.pmem_read || bus.pmem_write) begin
        cnt++;
        if (cnt > mem_lat) begin
          cnt = 0;
          bus.pmem_resp = 1;
          bus.pmem_rdata = line_of(bus.pmem_address);
        end
      end else cnt = 0;
    end
  end
  initial begin
    logic prev;
    txn_t t;
    txn_t lat;
    rsp_t r;
    prev = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev = 0;
        continue;
      end
      check("strobe_excl", 256'(bus.pmem_read & bus.pmem_write), 256'(0));
      if (bus.i_pmem_resp || bus.d_pmem_resp) begin
        check("resp_expected", 256'(rsp_q.size() != 0), 256'(1));
        if (rsp_q.size() != 0) begin
          r = rsp_q.pop_front();
          check("resp_sel", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(r.d ? 2'b01 : 2'b10));
          check("resp_data", r.d ? bus.d_pmem_rdata : bus.i_pmem_rdata, r.data);
          check("other_rdata", r.d ? bus.i_pmem_rdata : bus.d_pmem_rdata, '0);
        end
      end else check("rdata_quiet", bus.i_pmem_rdata | bus.d_pmem_rdata, '0);
      if ((bus.pmem_read || bus.pmem_write) && !prev) begin
        check("txn_expected", 256'(txn_q.size() != 0), 256'(1));
        if (txn_q.size() != 0) begin
          t = txn_q.pop_front();
          check("txn_op", 256'({bus.pmem_read, bus.pmem_write}), 256'({t.rd, t.wr}));
          check("txn_addr", 256'(bus.pmem_address), 256'(t.addr));
          if (t.wr) check("txn_wdata", bus.pmem_wdata, t.wdata);
        end
        lat.rd = bus.pmem_read; lat.wr = bus.pmem_write; lat.addr = bus.pmem_address; lat.wdata = bus.pmem_wdata;
      end else if (bus.pmem_read || bus.pmem_write) begin
        check("hold_op", 256'({bus.pmem_read, bus.pmem_write}), 256'({lat.rd, lat.wr}));
        check("hold_addr", 256'(bus.pmem_address), 256'(lat.addr));
        check("hold_wdata", bus.pmem_wdata, lat.wdata);
      end
      prev = bus.pmem_read | bus.pmem_write;
    end
  end
  initial begin
    int n;
    rst = 1; mon_en = 0; mem_lat = 4; spur_req = 0;
    bus.i_pmem_read = 0; bus.i_pmem_address = '0;
    bus.d_pmem_read = 0; bus.d_pmem_write = 0; bus.d_pmem_address = '0; bus.d_pmem_wdata = '0;
    step(1);
    @(negedge clk);
    check("rst_strobes", 256'({bus.pmem_read, bus.pmem_write}), 256'(0));
    check("rst_addr", 256'(bus.pmem_address), 256'(0));
    check("rst_wdata", bus.pmem_wdata, '0);
    check("rst_busy", 256'(bus.arb_busy), 256'(0));
    check("rst_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    check("rst_rdata", bus.i_pmem_rdata | bus.d_pmem_rdata, '0);
    step(1);
    rst = 0; mon_en = 1;
    // I-only fill: strobe cycles 1..5, response in cycle 5
    exp_txn(1, 0, 32'h60, '0); exp_rsp(0, {32{8'hAA}});
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h60;
    wait_resp(n);
    check("i_latency", 256'(n), 256'(6));
    check("busy_serve", 256'(bus.arb_busy), 256'(1));
    step(1);
    bus.i_pmem_read = 0;
    @(negedge clk);
    check("busy_done", 256'(bus.arb_busy), 256'(1));
    check("done_strobe", 256'(bus.pmem_read), 256'(0));
    @(negedge clk);
    check("busy_idle", 256'(bus.arb_busy), 256'(0));
    // simultaneous requests after reset: D wins the first tie
    rst = 1;
    step(1);
    rst = 0;
    bus.d_pmem_wdata = {8{32'h0BADF00D}};
    exp_txn(1, 0, 32'h200, '0); exp_rsp(1, {8{32'h200}});
    exp_txn(1, 0, 32'h100, '0); exp_rsp(0, {8{32'h100}});
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h100;
    bus.d_pmem_read = 1; bus.d_pmem_address = 32'h200;
    wait_resp(n);
    step(1);
    bus.d_pmem_read = 0;
    wait_resp(n);
    step(1);
    bus.i_pmem_read = 0;
    step(2);
    // both held continuously: strict alternation starting with D
    for (int k = 0; k < 2; k++) begin
      exp_txn(1, 0, 32'h300, '0); exp_rsp(1, {8{32'h300}});
      exp_txn(1, 0, 32'h340, '0); exp_rsp(0, {8{32'h340}});
    end
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h340;
    bus.d_pmem_read = 1; bus.d_pmem_address = 32'h300;
    repeat (4) wait_resp(n);
    step(1);
    bus.i_pmem_read = 0; bus.d_pmem_read = 0;
    step(2);
    // read+write together: writeback first, then the fill as its own transaction
    exp_txn(0, 1, 32'h400, {32{8'h55}}); exp_rsp(1, {8{32'h400}});
    exp_txn(1, 0, 32'h400, '0); exp_rsp(1, {8{32'h400}});
    bus.d_pmem_read = 1; bus.d_pmem_write = 1; bus.d_pmem_address = 32'h400; bus.d_pmem_wdata = {32{8'h55}};
    wait_resp(n);
    step(1);
    bus.d_pmem_write = 0;
    wait_resp(n);
    step(1);
    bus.d_pmem_read = 0;
    step(2);
    // spurious memory response while idle must not reach either cache
    spur_req++;
    repeat (4) begin
      @(negedge clk);
      check("spur_fwd", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
    end
    step(1);
    exp_txn(1, 0, 32'h500, '0); exp_rsp(1, {8{32'h500}});
    bus.d_pmem_read = 1; bus.d_pmem_address = 32'h500;
    step(2);
    bus.d_pmem_address = 32'h5C0; bus.d_pmem_wdata = {8{32'h12345678}};
    @(negedge clk);
    check("addr_latched", 256'(bus.pmem_address), 256'(32'h500));
    wait_resp(n);
    step(1);
    bus.d_pmem_read = 0;
    step(2);
    // reset in the middle of an I fill aborts it with no response
    mem_lat = 20;
    exp_txn(1, 0, 32'h600, '0);
    bus.i_pmem_read = 1; bus.i_pmem_address = 32'h600;
    step(3);
    rst = 1; bus.i_pmem_read = 0;
    step(1);
    @(negedge clk);
    check("abort_read", 256'(bus.pmem_read), 256'(0));
    check("abort_busy", 256'(bus.arb_busy), 256'(0));
    check("abort_resp", 256'(bus.i_pmem_resp), 256'(0));
    step(1);
    rst = 0; mem_lat = 4;
    repeat (25) @(negedge clk);
    check("txn_left", 256'(txn_q.size()), 256'(0));
    check("rsp_left", 256'(rsp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cacheline_arbiter.md
Name: cacheline_arbiter

Overview:
- Shares one physical-memory cacheline port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the two cache_p-style cache instances and the cacheline adaptor/physical memory.
- Registers the winning request, holds it stable until memory responds, then routes data and a response pulse back to the winner.
- Round-robin fairness prevents either cache from starving the other.

Parameters:
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, physical address width in bits.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- i_pmem_read  in  1  I-cache line-fill request; level, held until i_pmem_resp.
- i_pmem_address  in  ADDR_W  I-cache line address.
- i_pmem_rdata  out  LINE_W  line data to I-cache.
- i_pmem_resp  out  1  I-cache completion pulse.
- d_pmem_read  in  1  D-cache fill request; level.
- d_pmem_write  in  1  D-cache writeback request; level.
- d_pmem_address  in  ADDR_W  D-cache line address.
- d_pmem_wdata  in  LINE_W  D-cache writeback line.
- d_pmem_rdata  out  LINE_W  line data to D-cache.
- d_pmem_resp  out  1  D-cache completion pulse.
- pmem_read  out  1  memory read strobe; registered.
- pmem_write  out  1  memory write strobe; registered.
- pmem_address  out  ADDR_W  registered transaction address.
- pmem_wdata  out  LINE_W  registered writeback data.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion, one cycle.
- arb_busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D, DONE.
- Reset (synchronous, rst high at a clk edge):
  - state = IDLE; last_grant = I, so D wins the first tie.
  - pmem_read/pmem_write = 0; pmem_address/pmem_wdata = 0; arb_busy = 0.
  - Both resp outputs 0; both rdata outputs 0.
- IDLE:
  - Only I requesting -> SERVE_I.
  - Only D requesting -> SERVE_D.
  - Both requesting -> grant the side not equal to last_grant.
  - On grant, in the same edge: latch address (and d_pmem_wdata for D), set pmem_read or pmem_write, update last_grant.
  - Latency: request high in cycle N -> pmem strobe high in cycle N+1.
- SERVE_x:
  - pmem_read/pmem_write, pmem_address and pmem_wdata stay constant until pmem_resp.
  - Requester inputs are ignored after the grant. Deasserting a request mid-transaction is illegal; the transaction still completes and resp still pulses.
- Response:
  - In the cycle pmem_resp=1, x_pmem_resp=1 combinationally and x_pmem_rdata=pmem_rdata.
  - The other side's resp stays 0 and its rdata stays 0.
  - The next edge clears the strobes and moves to DONE.
- DONE:
  - Exactly one bubble cycle; no grant. This gives the winner a cycle to drop its request so it is not re-sampled.
  - Then -> IDLE.
- D opcode:
  - If d_pmem_read and d_pmem_write are both high at grant, write wins (writeback before fill). pmem_read=0, pmem_write=1.
  - The subsequent fill is a new request.
- pmem_read and pmem_write are never high together.
- Minimum back-to-back spacing is 3 cycles: grant, at least 1 serve cycle, DONE.
- pmem_resp while in IDLE or DONE is ignored; no resp is forwarded.
- rst mid-transaction: abort to IDLE next edge with strobes low. The outstanding memory response is dropped.
- No width conversion is done; all buses pass through at full LINE_W/ADDR_W.

Decomposition:
- Package cacheline_arb_pkg:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, DONE}.
  - arb_src_t enum {SRC_I, SRC_D}.
  - Localparams LINE_W_DEF=256, ADDR_W_DEF=32.
- Single module; no sub-module. The FSM plus request register is under ~200 lines.

Test Plan:
- I-only read of 0x0000_0060, memory responds after 4 cycles with line 0xAA..AA -> pmem_read high cycles 1-5, i_pmem_resp pulses once with rdata 0xAA..AA, d_pmem_resp stays 0.
- Both request in the same cycle after reset (I addr 0x100, D read 0x200) -> D served first (pmem_address=0x200), then I (0x100) after the DONE bubble.
- D holds a request continuously and I requests repeatedly -> grants strictly alternate D, I, D, I; no side waits more than one transaction.
- D asserts read+write at 0x400 with wdata 0x55..55 -> pmem_write=1, pmem_read=0, pmem_wdata=0x55..55; a later D read is a separate transaction.
- Spurious pmem_resp in IDLE, and D changes its address mid-SERVE_D -> no resp forwarded in IDLE; pmem_address stays at the latched value.
- rst asserted during SERVE_I -> next cycle state IDLE, pmem_read=0, arb_busy=0, no i_pmem_resp.
